// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: bus layouts, exception codes, FSM states.
package mem_pkg;

  localparam int unsigned EXE_MEM_BUS_W = 109;
  localparam int unsigned MEM_WB_BUS_W  = 73;

  // EXE_MEM_bus_r field positions
  localparam int unsigned EM_EXC_FLAG     = 108;
  localparam int unsigned EM_EXC_TYPE_MSB = 107;
  localparam int unsigned EM_EXC_TYPE_LSB = 106;
  localparam int unsigned EM_LS_LOAD      = 105;
  localparam int unsigned EM_LS_STORE     = 104;
  localparam int unsigned EM_LS_BYTE      = 103;
  localparam int unsigned EM_LS_SIGN      = 102;
  localparam int unsigned EM_SDATA_MSB    = 101;
  localparam int unsigned EM_SDATA_LSB    = 70;
  localparam int unsigned EM_RES_MSB      = 69;
  localparam int unsigned EM_RES_LSB      = 38;
  localparam int unsigned EM_WEN          = 37;
  localparam int unsigned EM_WDEST_MSB    = 36;
  localparam int unsigned EM_WDEST_LSB    = 32;
  localparam int unsigned EM_PC_MSB       = 31;
  localparam int unsigned EM_PC_LSB       = 0;

  // MEM_WB_bus field positions
  localparam int unsigned WB_EXC_FLAG     = 72;
  localparam int unsigned WB_EXC_TYPE_MSB = 71;
  localparam int unsigned WB_EXC_TYPE_LSB = 70;
  localparam int unsigned WB_WEN          = 69;
  localparam int unsigned WB_WDEST_MSB    = 68;
  localparam int unsigned WB_WDEST_LSB    = 64;
  localparam int unsigned WB_RESULT_MSB   = 63;
  localparam int unsigned WB_RESULT_LSB   = 32;
  localparam int unsigned WB_PC_MSB       = 31;
  localparam int unsigned WB_PC_LSB       = 0;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_LOAD_ALIGN  = 2'b01;
  localparam logic [1:0] EXC_STORE_ALIGN = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] byte_wen(input logic [1:0] offset);
    return 4'b0001 << offset;
  endfunction

  function automatic logic [MEM_WB_BUS_W-1:0] pack_wb(
    input logic        exc_flag,
    input logic [1:0]  exc_type,
    input logic        wen,
    input logic [4:0]  wdest,
    input logic [31:0] result,
    input logic [31:0] pc
  );
    return {exc_flag, exc_type, wen, wdest, result, pc};
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Byte lane selection and sign/zero extension of load data.
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic        byte_op,
  input  logic        sign_op,
  output logic [31:0] result
);

  logic [7:0] lane;

  always_comb begin
    lane = rdata[7:0];
    unique case (addr)
      2'd0: lane = rdata[7:0];
      2'd1: lane = rdata[15:8];
      2'd2: lane = rdata[23:16];
      2'd3: lane = rdata[31:24];
    endcase
    if (byte_op) begin
      result = {{24{sign_op & lane[7]}}, lane};
    end else begin
      result = rdata;
    end
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: data RAM access sequencing and MEM/WB bus generation.
// Optional: MEM_ALIGN_CHECK_EN enables misaligned word access exceptions;
// otherwise word addresses are forced to word alignment.
module mem_access
  import mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_valid,
  input  logic [EXE_MEM_BUS_W-1:0] EXE_MEM_bus_r,
  output logic                     dm_en,
  output logic [3:0]               dm_wen,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  input  logic [31:0]              dm_rdata,
  output logic                     MEM_over,
  output logic [MEM_WB_BUS_W-1:0]  MEM_WB_bus,
  output logic [31:0]              MEM_pc
);

  state_e                   state_q, state_d;
  logic [EXE_MEM_BUS_W-1:0] req_q, req_d;
  logic [MEM_WB_BUS_W-1:0]  wb_q, wb_d;

  // Request is latched on acceptance so a dropped MEM_valid or a changing
  // upstream bus cannot disturb an access already in flight.
  logic [EXE_MEM_BUS_W-1:0] cur;
  assign cur = (state_q == IDLE) ? EXE_MEM_bus_r : req_q;

  logic        exc_flag;
  logic [1:0]  exc_type;
  logic        is_load, is_store, is_byte, is_sign, mem_op;
  logic [31:0] store_data, exe_result, pc;
  logic        wen;
  logic [4:0]  wdest;
  logic        misaligned;
  logic [31:0] access_addr;
  logic [31:0] load_data;

  assign exc_flag   = cur[EM_EXC_FLAG];
  assign exc_type   = cur[EM_EXC_TYPE_MSB:EM_EXC_TYPE_LSB];
  assign is_load    = cur[EM_LS_LOAD];
  assign is_store   = cur[EM_LS_STORE] & ~cur[EM_LS_LOAD];
  assign is_byte    = cur[EM_LS_BYTE];
  assign is_sign    = cur[EM_LS_SIGN];
  assign mem_op     = is_load | is_store;
  assign store_data = cur[EM_SDATA_MSB:EM_SDATA_LSB];
  assign exe_result = cur[EM_RES_MSB:EM_RES_LSB];
  assign wen        = cur[EM_WEN];
  assign wdest      = cur[EM_WDEST_MSB:EM_WDEST_LSB];
  assign pc         = cur[EM_PC_MSB:EM_PC_LSB];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned  = mem_op & ~is_byte & (exe_result[1:0] != 2'b00);
  assign access_addr = exe_result;
`else
  assign misaligned  = 1'b0;
  assign access_addr = is_byte ? exe_result : {exe_result[31:2], 2'b00};
`endif

  load_align u_load_align (
    .rdata   (dm_rdata),
    .addr    (access_addr[1:0]),
    .byte_op (is_byte),
    .sign_op (is_sign),
    .result  (load_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wb_d    = wb_q;
    unique case (state_q)
      IDLE: begin
        if (MEM_valid) begin
          req_d = EXE_MEM_bus_r;
          if (exc_flag) begin
            state_d = DONE;
            wb_d    = pack_wb(1'b1, exc_type, wen, wdest, exe_result, pc);
          end else if (!mem_op) begin
            state_d = DONE;
            wb_d    = pack_wb(1'b0, EXC_NONE, wen, wdest, exe_result, pc);
          end else if (misaligned) begin
            state_d = DONE;
            wb_d    = pack_wb(1'b1, is_load ? EXC_LOAD_ALIGN : EXC_STORE_ALIGN,
                              wen, wdest, exe_result, pc);
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (is_load) begin
          state_d = WAIT;
        end else begin
          state_d = DONE;
          wb_d    = pack_wb(1'b0, EXC_NONE, wen, wdest, exe_result, pc);
        end
      end
      WAIT: begin
        state_d = DONE;
        wb_d    = pack_wb(1'b0, EXC_NONE, wen, wdest, load_data, pc);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wb_q    <= wb_d;
    end
  end

  assign dm_en      = (state_q == ISSUE);
  assign dm_wen     = (state_q == ISSUE && is_store)
                      ? (is_byte ? byte_wen(access_addr[1:0]) : 4'b1111)
                      : 4'b0000;
  assign dm_addr    = access_addr;
  assign dm_wdata   = is_byte ? {4{store_data[7:0]}} : store_data;
  assign MEM_over   = (state_q == DONE);
  assign MEM_WB_bus = wb_q;
  assign MEM_pc     = EXE_MEM_bus_r[EM_PC_MSB:EM_PC_LSB];

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic         clk = 1'b0;
  logic         rst;
  logic         MEM_valid;
  logic [108:0] EXE_MEM_bus_r;
  logic         dm_en;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [31:0]  dm_rdata;
  logic         MEM_over;
  logic [72:0]  MEM_WB_bus;
  logic [31:0]  MEM_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .dm_en         (dm_en),
    .dm_wen        (dm_wen),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_pc        (MEM_pc)
  );

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  typedef struct {
    int          lat;
    int          over_count;
    int          en_count;
    int          en_cycle;
    int          stray_wen;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [72:0] wb;
    logic [72:0] wb_end;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    int          lat;
    bit          acc;
    bit          is_store;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [72:0] wb;
  } exp_t;

  function automatic logic [108:0] mk(input logic exc, input logic [1:0] et, input logic [3:0] ls,
                                      input logic [31:0] sd, input logic [31:0] res,
                                      input logic wen, input logic [4:0] wd, input logic [31:0] pc);
    return {exc, et, ls, sd, res, wen, wd, pc};
  endfunction

  // Reference behaviour derived directly from the access rules.
  function automatic exp_t model(input logic [108:0] bus, input logic [31:0] resp);
    exp_t        e;
    logic        exc   = bus[108];
    logic [1:0]  et    = bus[107:106];
    logic [3:0]  ls    = bus[105:102];
    logic [31:0] sd    = bus[101:70];
    logic [31:0] res   = bus[69:38];
    logic        wen   = bus[37];
    logic [4:0]  wd    = bus[36:32];
    logic [31:0] pc    = bus[31:0];
    bit          ld    = ls[3];
    bit          st    = ls[2] && !ls[3];
    bit          by    = ls[1];
    bit          sg    = ls[0];
    int unsigned off   = res % 4;
    logic [31:0] bval;
    logic [31:0] ldres;
    e.lat = 1; e.acc = 0; e.is_store = st; e.wen = 4'h0; e.addr = '0; e.wdata = '0;
    if (exc) begin
      e.wb = {1'b1, et, wen, wd, res, pc};
    end else if (!ld && !st) begin
      e.wb = {1'b0, 2'b00, wen, wd, res, pc};
    end else if (ALIGN_ON && !by && off != 0) begin
      e.wb = {1'b1, (ld ? 2'b01 : 2'b10), wen, wd, res, pc};
    end else begin
      e.acc  = 1;
      e.addr = by ? res : (res & ~32'h3);
      if (st) begin
        e.lat   = 2;
        e.wen   = by ? 4'(1 << off) : 4'hF;
        e.wdata = by ? {4{sd[7:0]}} : sd;
        e.wb    = {1'b0, 2'b00, wen, wd, res, pc};
      end else begin
        e.lat = 3;
        bval  = (resp >> (8 * off)) & 32'hFF;
        if (by) ldres = (sg && bval[7]) ? (bval | 32'hFFFF_FF00) : bval;
        else    ldres = resp;
        e.wb = {1'b0, 2'b00, wen, wd, ldres, pc};
      end
    end
    return e;
  endfunction

  // Drives one operation and records six cycles of DUT behaviour; dm_rdata
  // carries resp only in the cycle following dm_en, garbage otherwise.
  task automatic run_op(input logic [108:0] bus, input logic [31:0] resp, input bit drop_valid,
                        output obs_t o);
    bit prev_en = 0;
    o.lat = 0; o.over_count = 0; o.en_count = 0; o.en_cycle = 0; o.stray_wen = 0;
    o.wen = 'x; o.addr = 'x; o.wdata = 'x; o.wb = 'x; o.wb_end = 'x;
    EXE_MEM_bus_r = bus;
    MEM_valid     = 1'b1;
    o.pc          = MEM_pc;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      dm_rdata = prev_en ? resp : $urandom;
      prev_en  = dm_en;
      if (c == 1 && drop_valid) MEM_valid = 1'b0;
      if (dm_en) begin
        o.en_count++;
        o.en_cycle = c;
        o.wen      = dm_wen;
        o.addr     = dm_addr;
        o.wdata    = dm_wdata;
      end else if (dm_wen !== 4'h0) begin
        o.stray_wen++;
      end
      if (MEM_over) begin
        o.over_count++;
        if (o.lat == 0) begin
          o.lat = c;
          o.wb  = MEM_WB_bus;
        end
        MEM_valid = 1'b0;
      end
    end
    MEM_valid = 1'b0;
    o.wb_end  = MEM_WB_bus;
  endtask

  task automatic test_reset();
    rst = 1'b1; MEM_valid = 1'b0; EXE_MEM_bus_r = '0; dm_rdata = '0;
    @(posedge clk); #1;
    checks++; if (MEM_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b exp 0", MEM_over); end
    checks++; if (dm_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", dm_en); end
    checks++; if (dm_wen !== 4'h0) begin errors++; $display("FAIL reset_wen got %h exp 0", dm_wen); end
    checks++; if (MEM_WB_bus !== 73'h0) begin errors++; $display("FAIL reset_wb got %h exp 0", MEM_WB_bus); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word_load();
    obs_t o;
    run_op(mk(1'b0, 2'b00, 4'b1000, 32'h0, 32'h100, 1'b1, 5'd3, 32'h4000), 32'hDEADBEEF, 1'b0, o);
    checks++; if (o.en_cycle !== 1) begin errors++; $display("FAIL wload_en_cycle got %0d exp 1", o.en_cycle); end
    checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL wload_addr got %h exp 100", o.addr); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL wload_lat got %0d exp 3", o.lat); end
    checks++; if (o.wb[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wload_result got %h exp deadbeef", o.wb[63:32]); end
    checks++; if (o.wb[72] !== 1'b0) begin errors++; $display("FAIL wload_exc got %b exp 0", o.wb[72]); end
    checks++; if (o.over_count !== 1) begin errors++; $display("FAIL wload_over_pulse got %0d exp 1", o.over_count); end
  endtask

  task automatic test_byte_store();
    obs_t o;
    run_op(mk(1'b0, 2'b00, 4'b0110, 32'h0000_00A5, 32'h103, 1'b0, 5'd0, 32'h4004), 32'h0, 1'b0, o);
    checks++; if (o.wen !== 4'b1000) begin errors++; $display("FAIL bstore_wen got %b exp 1000", o.wen); end
    checks++; if (o.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL bstore_wdata got %h exp a5a5a5a5", o.wdata); end
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL bstore_lat got %0d exp 2", o.lat); end
    checks++; if (o.wb[63:32] !== 32'h103) begin errors++; $display("FAIL bstore_result got %h exp 103", o.wb[63:32]); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_op(mk(1'b0, 2'b00, 4'b1011, 32'h0, 32'h101, 1'b1, 5'd7, 32'h4008), 32'h0000_80FF, 1'b0, o);
    checks++; if (o.wb[63:32] !== 32'hFFFFFF80) begin errors++; $display("FAIL bload_signed got %h exp ffffff80", o.wb[63:32]); end
    run_op(mk(1'b0, 2'b00, 4'b1010, 32'h0, 32'h101, 1'b1, 5'd7, 32'h400C), 32'h0000_80FF, 1'b0, o);
    checks++; if (o.wb[63:32] !== 32'h00000080) begin errors++; $display("FAIL bload_unsigned got %h exp 00000080", o.wb[63:32]); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL bload_lat got %0d exp 3", o.lat); end
  endtask

  task automatic test_misaligned_store();
    obs_t o;
    run_op(mk(1'b0, 2'b00, 4'b0100, 32'h1234_5678, 32'h102, 1'b0, 5'd0, 32'h4010), 32'h0, 1'b0, o);
    if (ALIGN_ON) begin
      checks++; if (o.en_count !== 0) begin errors++; $display("FAIL mis_store_en got %0d exp 0", o.en_count); end
      checks++; if (o.wb[72:70] !== 3'b110) begin errors++; $display("FAIL mis_store_exc got %b exp 110", o.wb[72:70]); end
      checks++; if (o.lat !== 1) begin errors++; $display("FAIL mis_store_lat got %0d exp 1", o.lat); end
    end else begin
      checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL mis_store_addr got %h exp 100", o.addr); end
      checks++; if (o.wen !== 4'b1111) begin errors++; $display("FAIL mis_store_wen got %b exp 1111", o.wen); end
      checks++; if (o.wb[72] !== 1'b0) begin errors++; $display("FAIL mis_store_exc got %b exp 0", o.wb[72]); end
    end
    checks++; if (o.stray_wen !== 0) begin errors++; $display("FAIL mis_store_stray got %0d exp 0", o.stray_wen); end
  endtask

  task automatic test_upstream_exc();
    obs_t o;
    run_op(mk(1'b1, 2'b11, 4'b1000, 32'h0, 32'h102, 1'b1, 5'd9, 32'h4014), 32'h0, 1'b0, o);
    checks++; if (o.en_count !== 0) begin errors++; $display("FAIL exc_en got %0d exp 0", o.en_count); end
    checks++; if (o.wb[72:70] !== 3'b111) begin errors++; $display("FAIL exc_bus got %b exp 111", o.wb[72:70]); end
    checks++; if (o.lat !== 1) begin errors++; $display("FAIL exc_lat got %0d exp 1", o.lat); end
  endtask

  task automatic test_reset_mid_op();
    obs_t o;
    EXE_MEM_bus_r = mk(1'b0, 2'b00, 4'b1000, 32'h0, 32'h200, 1'b1, 5'd1, 32'h5000);
    MEM_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MEM_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (MEM_over !== 1'b0) begin errors++; $display("FAIL rstmid_over got %b exp 0", MEM_over); end
    checks++; if (MEM_WB_bus !== 73'h0) begin errors++; $display("FAIL rstmid_wb got %h exp 0", MEM_WB_bus); end
    @(posedge clk); #1;
    checks++; if (dm_en !== 1'b0 || dm_wen !== 4'h0) begin errors++; $display("FAIL rstmid_access got en=%b wen=%h exp 0/0", dm_en, dm_wen); end
    run_op(mk(1'b0, 2'b00, 4'b0000, 32'h0, 32'hCAFE_0001, 1'b1, 5'd2, 32'h5004), 32'h0, 1'b0, o);
    checks++; if (o.lat !== 1) begin errors++; $display("FAIL rstmid_next_lat got %0d exp 1", o.lat); end
    checks++; if (o.wb !== {1'b0, 2'b00, 1'b1, 5'd2, 32'hCAFE_0001, 32'h5004}) begin
      errors++; $display("FAIL rstmid_next_wb got %h exp %h", o.wb, {1'b0, 2'b00, 1'b1, 5'd2, 32'hCAFE_0001, 32'h5004});
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [108:0] bus;
    logic [31:0] resp;
    for (int n = 0; n < 80; n++) begin
      logic exc = ($urandom_range(0, 5) == 0);
      bus  = mk(exc, exc ? 2'($urandom) : 2'b00, 4'($urandom), $urandom, $urandom,
                1'($urandom), 5'($urandom), $urandom);
      resp = $urandom;
      e    = model(bus, resp);
      run_op(bus, resp, 1'($urandom), o);
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d_lat got %0d exp %0d", n, o.lat, e.lat); end
      checks++; if (o.over_count !== 1) begin errors++; $display("FAIL rnd%0d_over_pulse got %0d exp 1", n, o.over_count); end
      checks++; if (o.en_count !== int'(e.acc)) begin errors++; $display("FAIL rnd%0d_en_count got %0d exp %0d", n, o.en_count, e.acc); end
      checks++; if (o.stray_wen !== 0) begin errors++; $display("FAIL rnd%0d_stray_wen got %0d exp 0", n, o.stray_wen); end
      checks++; if (o.wb !== e.wb) begin errors++; $display("FAIL rnd%0d_wb got %h exp %h", n, o.wb, e.wb); end
      checks++; if (o.wb_end !== e.wb) begin errors++; $display("FAIL rnd%0d_wb_held got %h exp %h", n, o.wb_end, e.wb); end
      checks++; if (o.pc !== bus[31:0]) begin errors++; $display("FAIL rnd%0d_pc got %h exp %h", n, o.pc, bus[31:0]); end
      if (e.acc) begin
        checks++; if (o.en_cycle !== 1) begin errors++; $display("FAIL rnd%0d_en_cycle got %0d exp 1", n, o.en_cycle); end
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", n, o.addr, e.addr); end
        checks++; if (o.wen !== e.wen) begin errors++; $display("FAIL rnd%0d_wen got %b exp %b", n, o.wen, e.wen); end
        if (e.is_store) begin
          checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, o.wdata, e.wdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_misaligned_store();
    test_upstream_exc();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
